vram_write_arbiter: RTL and testbench
=====================================

Name: vram_write_arbiter

Overview:
Sits between the CPU-side VRAM interface (`data`/`address`/`cs`), the GPU pixel fetch path and the single-port VRAM.
- CPU writes are queued in a parametrised FIFO and drained into VRAM only in cycles the GPU does not need the RAM.
- When `BLANK_ONLY`=1, draining is further restricted to vertical blanking.
- Successor to the fixed-width top-level VRAM hookup: adds buffering, arbitration, occupancy and overflow reporting.

Parameters:
- ADDR_WIDTH, 15, VRAM address width (matches `VRAM_ADDR_WIDTH`).
- DATA_WIDTH, 8, VRAM data width.
- DEPTH, 16, write-FIFO entries; power of two, ≥2.
- BLANK_ONLY, 0, 1 = drain only while `vblank`=1; 0 = drain in any GPU-idle cycle.

Ports:
- clk  in  1  pixel clock (12.5875 MHz).
- rst  in  1  asynchronous active-high reset.
- cs  in  1  CPU write strobe; one write per cycle when high.
- address  in  ADDR_WIDTH  CPU write address.
- data  in  DATA_WIDTH  CPU write data.
- full  out  1  FIFO holds DEPTH entries.
- level  out  $clog2(DEPTH+1)  current FIFO occupancy.
- overflow  out  1  sticky: a write was dropped.
- vblank  in  1  vertical blanking indicator from the timing generator.
- gpu_rd  in  1  GPU read request.
- gpu_addr  in  ADDR_WIDTH  GPU read address.
- gpu_data  out  DATA_WIDTH  read data.
- gpu_valid  out  1  `gpu_data` valid this cycle.
- vram_addr  out  ADDR_WIDTH  registered VRAM address.
- vram_wdata  out  DATA_WIDTH  registered VRAM write data.
- vram_we  out  1  registered write enable.
- vram_oe  out  1  registered output enable.
- vram_rdata  in  DATA_WIDTH  VRAM read data.

Behaviour:
- Reset (async assert, sync release): FIFO empty, `level`=0, `full`=0, `overflow`=0. All `vram_*`=0, `gpu_data`=0, `gpu_valid`=0.
- Push (cycle N, `cs`=1):
  - Entry {address,data} is written at the tail when `level`<DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the write is dropped and `overflow` is set at N+1. `overflow` stays set until `rst`.
- Arbiter, evaluated each cycle from current-cycle inputs; registered outputs take effect at N+1:
  - GRANT_GPU if `gpu_rd`=1: `vram_oe`=1, `vram_we`=0, `vram_addr`=`gpu_addr`. GPU always wins; no starvation guard for writes.
  - Else GRANT_WR if FIFO non-empty and (`BLANK_ONLY`=0 or `vblank`=1): pop head; `vram_we`=1, `vram_oe`=0, `vram_addr`/`vram_wdata` = head entry.
  - Else IDLE: `vram_we`=`vram_oe`=0; address/wdata hold their previous values.
- Read latency: `gpu_rd` at N → `vram_oe` at N+1 → `gpu_data`=`vram_rdata` registered and `gpu_valid`=1 at N+2. Back-to-back reads are fully pipelined, one per cycle.
- `vram_we` and `vram_oe` are never both 1.
- No read-after-write forwarding: a GPU read of an address with a pending queued write returns the old RAM contents.
- Pointers are log2(DEPTH) bits and wrap naturally. `level` is the registered count, updated +1 push, −1 pop, 0 net on push+pop.
- `full` = (`level`==DEPTH), registered alongside `level`.
- Mid-operation reset: queued writes are discarded; an in-flight read loses `gpu_valid` immediately.

Decomposition:
- Shared package/header (`parameters.v`): `VRAM_ADDR_WIDTH`, `VRAM_DATA_WIDTH`, default FIFO depth, grant encoding constants (GRANT_IDLE=0, GRANT_GPU=1, GRANT_WR=2).
- One sub-module: `sync_fifo_m`, a parametrised width/depth FIFO with push/pop/level/full/empty. The arbiter and read pipeline stay in the top module.

Test Plan:
- Reset, then 3 writes (A=0x0010/0x11, 0x0011/0x22, 0x0012/0x33) with `gpu_rd`=0, `BLANK_ONLY`=0 → `vram_we` pulses on 3 consecutive cycles starting 1 cycle after the first pop, in order A; `level` returns to 0.
- Continuous `gpu_rd` at addr 0x0100 while 2 writes are queued → no `vram_we`; `gpu_valid` 2 cycles after each request with `gpu_data`=RAM[0x0100]. Drop `gpu_rd` → writes drain next cycles.
- DEPTH=4, GPU busy, 5 writes → `full`=1 after the 4th; 5th dropped; `overflow`=1 and stays 1; `level`=4.
- `BLANK_ONLY`=1, `vblank`=0, `gpu_rd`=0, 2 writes queued → nothing drains. Raise `vblank` → both drain, `level` 0.
- FIFO full and GPU idle, `cs`=1 with a simultaneous pop → push accepted, `level` stays 4, `overflow` stays 0.
- Assert `rst` mid-drain with `level`=3 → all outputs 0 immediately; after release no further `vram_we`.

Source files
------------

// File: rtl/vram_write_arbiter_pkg.sv
// Shared widths, default FIFO depth and the arbiter grant encoding for the
// VRAM write arbiter slice.
package vram_write_arbiter_pkg;

  localparam int VRAM_ADDR_WIDTH = 15;
  localparam int VRAM_DATA_WIDTH = 8;
  localparam int FIFO_DEPTH_DEF  = 16;

  typedef enum logic [1:0] {
    GRANT_IDLE = 2'd0,
    GRANT_GPU  = 2'd1,
    GRANT_WR   = 2'd2
  } grant_e;

  // GPU fetch always wins; queued CPU writes only take otherwise-idle slots.
  function automatic grant_e arbitrate(input logic gpu_rd,
                                       input logic fifo_empty,
                                       input logic drain_ok);
    if (gpu_rd)                       return GRANT_GPU;
    else if (!fifo_empty && drain_ok) return GRANT_WR;
    else                              return GRANT_IDLE;
  endfunction

endpackage

// File: rtl/vram_write_arbiter_if.sv
// Bundle of CPU write port, GPU fetch port and VRAM pins around the arbiter.
// master = surrounding system, slave = the arbiter itself.
interface vram_write_arbiter_if
  import vram_write_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = VRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = VRAM_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH_DEF
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic                  cs;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data;
  logic                  full;
  logic [LVL_W-1:0]      level;
  logic                  overflow;
  logic                  vblank;
  logic                  gpu_rd;
  logic [ADDR_WIDTH-1:0] gpu_addr;
  logic [DATA_WIDTH-1:0] gpu_data;
  logic                  gpu_valid;
  logic [ADDR_WIDTH-1:0] vram_addr;
  logic [DATA_WIDTH-1:0] vram_wdata;
  logic                  vram_we;
  logic                  vram_oe;
  logic [DATA_WIDTH-1:0] vram_rdata;

  modport master (
    output cs, address, data, vblank, gpu_rd, gpu_addr, vram_rdata,
    input  full, level, overflow, gpu_data, gpu_valid,
           vram_addr, vram_wdata, vram_we, vram_oe
  );

  modport slave (
    input  cs, address, data, vblank, gpu_rd, gpu_addr, vram_rdata,
    output full, level, overflow, gpu_data, gpu_valid,
           vram_addr, vram_wdata, vram_we, vram_oe
  );

endinterface

// File: rtl/vram_write_arbiter_fifo.sv
// sync_fifo_m: parametrised-width/depth synchronous FIFO with registered
// level/full and a combinational head word.
module sync_fifo_m #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_accept,
  output logic [LVL_W-1:0] o_level,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0] r_level, w_level_nxt;
  logic             r_full;
  logic             w_push_ok, w_pop_ok;

  assign o_empty   = (r_level == '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push_ok = i_push && (!r_full || i_pop);
  assign w_pop_ok  = i_pop && !o_empty;

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_level_nxt = r_level + 1'b1;
      2'b01:   w_level_nxt = r_level - 1'b1;
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LVL_W'(DEPTH));
    end
  end

  assign o_dout   = r_mem[r_rd_ptr];
  assign o_accept = w_push_ok;
  assign o_level  = r_level;
  assign o_full   = r_full;

endmodule

// File: rtl/vram_write_arbiter.sv
// Queues CPU VRAM writes and slots them into cycles the GPU fetch path leaves
// idle; all VRAM pins and the GPU read return are registered.
module vram_write_arbiter
  import vram_write_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = VRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = VRAM_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH_DEF,
  parameter bit BLANK_ONLY = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  vram_write_arbiter_if.slave  bus
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int EW    = ADDR_WIDTH + DATA_WIDTH;

  logic [EW-1:0]         w_head;
  logic                  w_accept, w_full, w_empty, w_pop, w_drain_ok;
  logic [LVL_W-1:0]      w_level;
  grant_e                w_grant;

  logic [ADDR_WIDTH-1:0] r_vram_addr;
  logic [DATA_WIDTH-1:0] r_vram_wdata;
  logic                  r_vram_we, r_vram_oe;
  logic [DATA_WIDTH-1:0] r_gpu_data;
  logic                  r_gpu_valid;
  logic                  r_overflow;

  sync_fifo_m #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_push   (bus.cs),
    .i_din    ({bus.address, bus.data}),
    .i_pop    (w_pop),
    .o_dout   (w_head),
    .o_accept (w_accept),
    .o_level  (w_level),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  assign w_drain_ok = !BLANK_ONLY || bus.vblank;
  assign w_grant    = arbitrate(bus.gpu_rd, w_empty, w_drain_ok);
  assign w_pop      = (w_grant == GRANT_WR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vram_addr  <= '0;
      r_vram_wdata <= '0;
      r_vram_we    <= 1'b0;
      r_vram_oe    <= 1'b0;
    end else begin
      case (w_grant)
        GRANT_GPU: begin
          r_vram_oe   <= 1'b1;
          r_vram_we   <= 1'b0;
          r_vram_addr <= bus.gpu_addr;
        end
        GRANT_WR: begin
          r_vram_we    <= 1'b1;
          r_vram_oe    <= 1'b0;
          r_vram_addr  <= w_head[EW-1:DATA_WIDTH];
          r_vram_wdata <= w_head[DATA_WIDTH-1:0];
        end
        default: begin
          r_vram_we <= 1'b0;
          r_vram_oe <= 1'b0;
        end
      endcase
    end
  end

  // Second read stage: capture RAM data during the oe cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gpu_data  <= '0;
      r_gpu_valid <= 1'b0;
    end else begin
      r_gpu_valid <= r_vram_oe;
      if (r_vram_oe) r_gpu_data <= bus.vram_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_overflow <= 1'b0;
    else if (bus.cs && !w_accept) r_overflow <= 1'b1;
  end

  assign bus.full       = w_full;
  assign bus.level      = w_level;
  assign bus.overflow   = r_overflow;
  assign bus.vram_addr  = r_vram_addr;
  assign bus.vram_wdata = r_vram_wdata;
  assign bus.vram_we    = r_vram_we;
  assign bus.vram_oe    = r_vram_oe;
  assign bus.gpu_data   = r_gpu_data;
  assign bus.gpu_valid  = r_gpu_valid;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Scoreboard bench: two arbiters (BLANK_ONLY 0 and 1, DEPTH 4) share stimulus,
// each with its own RAM model; writes and reads are checked against queues.
module tb_vram_write_arbiter;

  localparam int AW  = 15;
  localparam int DW  = 8;
  localparam int DEP = 4;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { logic [DW-1:0] d; int due; } rd_t;

  logic clk = 1'b0;
  logic rst;
  logic cs, vblank, gpu_rd;
  logic [AW-1:0] address, gpu_addr;
  logic [DW-1:0] data;

  logic [DW-1:0] ram_a [0:(1<<AW)-1];
  logic [DW-1:0] ram_b [0:(1<<AW)-1];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, b_we_cnt = 0, n_rd_seen = 0;
  logic rd_at_edge = 1'b0;
  logic [AW-1:0] rd_addr_edge;
  wr_t exp_wa[$], exp_wb[$];
  rd_t exp_rd[$];
  int  we_cyc[$];

  always #5 clk = ~clk;

  vram_write_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP)) bus ();
  vram_write_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP)) busb ();

  vram_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .BLANK_ONLY(1'b0))
    dut (.clk(clk), .rst(rst), .bus(bus));
  vram_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .BLANK_ONLY(1'b1))
    dutb (.clk(clk), .rst(rst), .bus(busb));

  assign bus.cs = cs;           assign busb.cs = cs;
  assign bus.address = address; assign busb.address = address;
  assign bus.data = data;       assign busb.data = data;
  assign bus.vblank = vblank;   assign busb.vblank = vblank;
  assign bus.gpu_rd = gpu_rd;   assign busb.gpu_rd = gpu_rd;
  assign bus.gpu_addr = gpu_addr; assign busb.gpu_addr = gpu_addr;
  assign bus.vram_rdata  = ram_a[bus.vram_addr];
  assign busb.vram_rdata = ram_b[busb.vram_addr];

  always @(posedge clk) begin
    if (bus.vram_we)  ram_a[bus.vram_addr]  <= bus.vram_wdata;
    if (busb.vram_we) ram_b[busb.vram_addr] <= busb.vram_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Record which reads the DUT registers at this edge and when data is due.
  always @(posedge clk) begin
    cyc++;
    rd_at_edge   = gpu_rd && !rst;
    rd_addr_edge = gpu_addr;
    if (rd_at_edge) exp_rd.push_back('{ram_a[gpu_addr], cyc + 1});
  end

  always @(negedge clk) begin
    wr_t w;
    rd_t r;
    if (!rst) begin
      if (bus.vram_we || bus.vram_oe) chk("we_oe_excl", bus.vram_we & bus.vram_oe, 0);
      if (rd_at_edge) begin
        chk("rd_oe", bus.vram_oe, 1);
        chk("rd_addr", bus.vram_addr, rd_addr_edge);
      end
      if (bus.vram_we) begin
        chk("no_we_under_rd", rd_at_edge, 0);
        we_cyc.push_back(cyc);
        chk("wr_pending", exp_wa.size() > 0, 1);
        if (exp_wa.size() > 0) begin
          w = exp_wa.pop_front();
          chk("wr_addr", bus.vram_addr, w.a);
          chk("wr_data", bus.vram_wdata, w.d);
        end
      end
      if (bus.gpu_valid) begin
        n_rd_seen++;
        chk("rd_pending", exp_rd.size() > 0, 1);
        if (exp_rd.size() > 0) begin
          r = exp_rd.pop_front();
          chk("rd_data", bus.gpu_data, r.d);
          chk("rd_latency", cyc, r.due);
        end
      end
      if (busb.vram_we) begin
        b_we_cnt++;
        chk("b_wr_pending", exp_wb.size() > 0, 1);
        if (exp_wb.size() > 0) begin
          w = exp_wb.pop_front();
          chk("b_wr_addr", busb.vram_addr, w.a);
          chk("b_wr_data", busb.vram_wdata, w.d);
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_we"},     bus.vram_we, 0);
    chk({tag, "_oe"},     bus.vram_oe, 0);
    chk({tag, "_addr"},   bus.vram_addr, 0);
    chk({tag, "_wdata"},  bus.vram_wdata, 0);
    chk({tag, "_gdata"},  bus.gpu_data, 0);
    chk({tag, "_gvalid"}, bus.gpu_valid, 0);
    chk({tag, "_level"},  bus.level, 0);
    chk({tag, "_full"},   bus.full, 0);
    chk({tag, "_ovf"},    bus.overflow, 0);
  endtask

  task automatic flush_sb();
    exp_wa.delete(); exp_wb.delete(); exp_rd.delete(); we_cyc.delete();
    b_we_cnt = 0; n_rd_seen = 0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk_zero(tag);
    flush_sb();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit accept);
    cs = 1'b1; address = a; data = d;
    if (accept) begin
      exp_wa.push_back('{a, d});
      exp_wb.push_back('{a, d});
    end
    @(negedge clk);
    cs = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram_a[i] = 8'(i ^ (i >> 8));
      ram_b[i] = '0;
    end
    rst = 1'b1; cs = 1'b0; vblank = 1'b1; gpu_rd = 1'b0;
    address = '0; data = '0; gpu_addr = 15'h0100;
    @(negedge clk);
    do_reset("rst0");

    // Three back-to-back writes drain on consecutive cycles.
    do_wr(15'h0010, 8'h11, 1);
    do_wr(15'h0011, 8'h22, 1);
    do_wr(15'h0012, 8'h33, 1);
    repeat (4) @(negedge clk);
    chk("t1_we_count", we_cyc.size(), 3);
    if (we_cyc.size() >= 3) begin
      chk("t1_gap0", we_cyc[1] - we_cyc[0], 1);
      chk("t1_gap1", we_cyc[2] - we_cyc[1], 1);
    end
    chk("t1_level", bus.level, 0);
    chk("t1_sb_empty", exp_wa.size(), 0);

    // GPU hogs the RAM; writes wait, reads return with 2-cycle latency.
    gpu_rd = 1'b1; gpu_addr = 15'h0100;
    do_wr(15'h0020, 8'hA1, 1);
    do_wr(15'h0021, 8'hA2, 1);
    repeat (4) @(negedge clk);
    chk("t2_level_held", bus.level, 2);
    chk("t2_reads_seen", n_rd_seen >= 4, 1);
    gpu_rd = 1'b0;
    repeat (4) @(negedge clk);
    chk("t2_level", bus.level, 0);
    chk("t2_wr_sb", exp_wa.size(), 0);
    chk("t2_rd_sb", exp_rd.size(), 0);

    // Overflow: fifth write into a full FIFO is dropped, flag is sticky.
    do_reset("rst3");
    gpu_rd = 1'b1; gpu_addr = 15'h0123;
    for (int i = 0; i < 4; i++) do_wr(15'h0030 + 15'(i), 8'hC0 + 8'(i), 1);
    chk("t3_full", bus.full, 1);
    chk("t3_level4", bus.level, 4);
    chk("t3_no_ovf_yet", bus.overflow, 0);
    do_wr(15'h0034, 8'hC4, 0);
    chk("t3_ovf", bus.overflow, 1);
    chk("t3_level_after", bus.level, 4);
    gpu_rd = 1'b0;
    repeat (6) @(negedge clk);
    chk("t3_ovf_sticky", bus.overflow, 1);
    chk("t3_drained", bus.level, 0);
    chk("t3_full_clr", bus.full, 0);
    chk("t3_wr_sb", exp_wa.size(), 0);

    // Blank-only instance holds writes until vblank.
    do_reset("rst4");
    vblank = 1'b0;
    do_wr(15'h0040, 8'hD0, 1);
    do_wr(15'h0041, 8'hD1, 1);
    repeat (4) @(negedge clk);
    chk("t4_b_level", busb.level, 2);
    chk("t4_b_no_we", b_we_cnt, 0);
    chk("t4_a_level", bus.level, 0);
    vblank = 1'b1;
    repeat (4) @(negedge clk);
    chk("t4_b_drained", busb.level, 0);
    chk("t4_b_we", b_we_cnt, 2);
    chk("t4_b_sb", exp_wb.size(), 0);

    // Full FIFO with a simultaneous pop still accepts the push.
    do_reset("rst5");
    gpu_rd = 1'b1;
    for (int i = 0; i < 4; i++) do_wr(15'h0050 + 15'(i), 8'hE0 + 8'(i), 1);
    gpu_rd = 1'b0;
    do_wr(15'h0054, 8'hE4, 1);
    chk("t5_level4", bus.level, 4);
    chk("t5_full", bus.full, 1);
    chk("t5_no_ovf", bus.overflow, 0);
    repeat (7) @(negedge clk);
    chk("t5_drained", bus.level, 0);
    chk("t5_ovf_still0", bus.overflow, 0);
    chk("t5_wr_sb", exp_wa.size(), 0);

    // Reset mid-drain discards the queue and kills the in-flight read.
    do_reset("rst6");
    gpu_rd = 1'b1;
    for (int i = 0; i < 4; i++) do_wr(15'h0060 + 15'(i), 8'hF0 + 8'(i), 1);
    gpu_rd = 1'b0;
    @(negedge clk);
    chk("t6_level3", bus.level, 3);
    do_reset("t6_rst");
    repeat (10) @(negedge clk);
    chk("t6_no_we", we_cyc.size(), 0);
    chk("t6_level", bus.level, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
